multi_edge_detect: RTL
======================

// Module: multi_edge_detect
// PURPOSE
//   Multi-channel edge detector for asynchronous inputs. Each channel has a synchroniser
//   and a glitch filter, then produces one-cycle rise/fall pulses.
//   Selected edges set sticky pending flags, which drive a maskable interrupt and a
//   saturating event counter.
//   Sits between raw pad/status inputs and the control/interrupt logic.
// PARAMETERS
//   WIDTH        8   number of independent input channels (>=1)
//   SYNC_STAGES  2   synchroniser flops per channel (>=2)
//   FILTER_CNT   3   consecutive stable samples needed to accept a new level (0 = no filter)
//   CNT_W        8   width of the event counter (>= clog2(WIDTH+1))
// PORTS
//   clk       in   1            clock, all logic on rising edge
//   rst_n     in   1            reset, asynchronous, active-low
//   din       in   WIDTH        raw asynchronous inputs
//   edge_sel  in   2            00 none, 01 rise, 10 fall, 11 both; selects which edges set pending
//   irq_en    in   WIDTH        per-channel interrupt enable
//   evt_clr   in   WIDTH        per-channel pending clear, single-cycle pulse
//   cnt_clr   in   1            event counter clear, single-cycle pulse
//   rise      out  WIDTH        registered 1-cycle pulse per filtered 0->1 transition
//   fall      out  WIDTH        registered 1-cycle pulse per filtered 1->0 transition
//   evt_pend  out  WIDTH        sticky pending flags
//   irq       out  1            registered OR of (evt_pend & irq_en)
//   evt_cnt   out  CNT_W        saturating count of selected edges, all channels
// BEHAVIOUR
//   Reset values
//   - On rst_n low, all of the following are 0: sync flops, filter counters, filtered levels,
//     rise, fall, evt_pend, irq and evt_cnt.
//   Synchroniser
//   - Each channel has a SYNC_STAGES-deep flop chain; s[i] is its last stage.
//   Filter (per channel)
//   - Holds filtered level f[i] and a counter.
//   - When s[i]==f[i]: the counter clears.
//   - When s[i]!=f[i]: the counter increments.
//   - f[i] takes s[i] on the cycle the counter reaches FILTER_CNT; the counter then clears.
//   - With FILTER_CNT=0, f[i] follows s[i] every cycle.
//   - A pulse shorter than FILTER_CNT samples is dropped and produces no edge.
//   Edge outputs
//   - rise[i] = f[i] & ~f_d[i]; fall[i] = ~f[i] & f_d[i]; both registered.
//   - Latency: a clean step on din, held, gives rise/fall high exactly
//     L = SYNC_STAGES+FILTER_CNT+1 cycles after the first clk edge that samples the new level.
//   - A pulse lasts exactly 1 cycle. rise and fall are never high together on a channel.
//   - f resets to 0, so a din held high through reset release yields one rise after L cycles.
//   Selection and pending flags
//   - sel[i] = (edge_sel[0] & rise[i]) | (edge_sel[1] & fall[i]).
//   - evt_pend[i] sets on the cycle after sel[i]. evt_clr[i] clears it on the next cycle.
//   - If sel[i] and evt_clr[i] coincide, set wins and evt_pend[i] stays 1.
//   - edge_sel=00: no new pending and no counting; rise/fall still pulse.
//   irq
//   - Registered, so it lags evt_pend by 1 cycle.
//   - Changing irq_en affects irq on the next cycle.
//   evt_cnt
//   - Each cycle: evt_cnt <= min(evt_cnt + popcount(sel), 2^CNT_W-1).
//   - The add is done at CNT_W+1 bits and saturates; it never wraps.
//   - cnt_clr with simultaneous events: evt_cnt <= popcount(sel) this cycle; events are not lost.
//   Reset mid-operation
//   - All state is discarded immediately, with no pulse or count generated by the reset itself.
// TESTING
//   - T1 latency (defaults): din[0] 0->1, held -> rise[0] one cycle at L=6; evt_pend[0]=1 at 7 and
//     irq=1 at 8 with irq_en[0]=1 and edge_sel=01; fall[0] stays 0.
//   - T2 glitch: din[3] high 2 cycles, then low -> no rise/fall. High for 3 samples -> rise[3]
//     after 6 cycles; then low for 3 samples -> fall[3].
//   - T3 mode/clear: edge_sel=10, toggle din[1] up/down -> only fall sets evt_pend[1].
//     evt_clr[1] on the same cycle as a new sel -> evt_pend[1] stays 1; a later lone clr -> 0.
//   - T4 count: all 8 channels rise together with edge_sel=11 -> evt_cnt +8. Drive to 250, then
//     8 more -> evt_cnt=255 (saturated). cnt_clr with 3 concurrent events -> evt_cnt=3.
//   - T5 reset: rst_n low mid-filter, with the counter at 2, and with din high -> all outputs 0
//     at once. After release, with din still high -> one rise per channel at L=6, count=WIDTH.

Source files
------------

// File: rtl/multi_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : multi_edge_detect
// Purpose  : Per-channel synchroniser + glitch filter + edge pulses, feeding
//            sticky pending flags, a maskable irq and a saturating event count.
// Revision : 1.0
// ============================================================================
module multi_edge_detect #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CNT  = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       edge_sel,
  input  logic [WIDTH-1:0] irq_en,
  input  logic [WIDTH-1:0] evt_clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] evt_pend,
  output logic             irq,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam int c_fc_w = (FILTER_CNT > 0) ? $clog2(FILTER_CNT + 1) : 1;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_f;
  logic [WIDTH-1:0] r_f_d;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_pend;
  logic             r_irq;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_sel;
  logic [CNT_W:0]   w_pop;
  logic [CNT_W:0]   w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  generate
    if (FILTER_CNT == 0) begin : g_nofilt
      assign w_f = w_s;
    end else begin : g_filt
      logic [c_fc_w-1:0] r_fcnt [WIDTH];
      logic [WIDTH-1:0]  r_flt;

      // Level is accepted on the sample that makes the mismatch run FILTER_CNT long
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_flt <= '0;
          for (int i = 0; i < WIDTH; i++) r_fcnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (w_s[i] == r_flt[i]) begin
              r_fcnt[i] <= '0;
            end else if (r_fcnt[i] == c_fc_w'(FILTER_CNT - 1)) begin
              r_flt[i]  <= w_s[i];
              r_fcnt[i] <= '0;
            end else begin
              r_fcnt[i] <= r_fcnt[i] + 1'b1;
            end
          end
        end
      end

      assign w_f = r_flt;
    end
  endgenerate

  assign w_sel = ({WIDTH{edge_sel[0]}} & r_rise) | ({WIDTH{edge_sel[1]}} & r_fall);

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) w_pop = w_pop + (CNT_W + 1)'(w_sel[i]);
  end

  assign w_sum = (cnt_clr ? '0 : {1'b0, r_cnt}) + w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_d  <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_pend <= '0;
      r_irq  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_f_d  <= w_f;
      r_rise <= w_f & ~r_f_d;
      r_fall <= ~w_f & r_f_d;
      // A new selected edge outranks a clear in the same cycle
      r_pend <= (r_pend & ~evt_clr) | w_sel;
      r_irq  <= |(r_pend & irq_en);
      r_cnt  <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end
  end

  assign rise     = r_rise;
  assign fall     = r_fall;
  assign evt_pend = r_pend;
  assign irq      = r_irq;
  assign evt_cnt  = r_cnt;

endmodule
`default_nettype wire
